uart_rx_core: RTL and testbench

Receive front end of the UART peripheral: synchronises the `rx` pin, detects start bits with 16x oversampling, shifts in 8N1 frames LSB first, and presents each byte to the bus-facing UART register logic through a one-entry valid/ready holding register. It sits directly upstream of the peripheral's RX data register. It also drives `rts` so the remote transmitter pauses while a byte is held.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_core.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART RX and TX cores.
//   uart_rx_state_t : receive FSM state encoding
//   OVERSAMPLE      : oversample ticks per bit
//   MID_SAMPLE      : tick index of the mid-bit sample inside the start bit
//   DATA_BITS       : data bits per frame
// Optional feature macro: UART_RX_PARITY_EN (adds the RX_PARITY state).
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;
  localparam int unsigned DATA_BITS  = 8;

  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, shared by the RX and TX cores.
//   clk      : clock
//   nReset   : asynchronous reset, active-high
//   clear    : hold the counter at 0 (restarts tick phase)
//   baud_div : clocks per tick; 0 behaves as 1
//   tick     : one-cycle pulse every baud_div clocks while clear is low
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             clear,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;

  assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign tick    = ~clear && (cnt == div_eff - DIV_W'(1));

  always_ff @(posedge clk or posedge nReset) begin
    if (nReset)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive front end (8N1, or 8E1/8O1 with parity).
//   clk        : clock, rising edge
//   nReset     : asynchronous reset, active-high (1 = in reset)
//   rx         : serial input, idle high, asynchronous
//   baud_div   : clocks per oversample tick (0 treated as 1), captured in idle
//   rx_data    : held byte
//   rx_valid   : rx_data is valid
//   rx_ready   : consumer accepts the held byte this cycle
//   frame_err  : stop bit of the held byte sampled 0
//   parity_err : parity mismatch on the held byte (0 without parity)
//   overrun    : one-cycle pulse when a completed byte is dropped
//   rts        : registered ~rx_valid, 1 = can accept
// Optional feature macro: UART_RX_PARITY_EN (adds parameter PARITY_ODD).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_W       = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit        PARITY_ODD  = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             rts
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [DIV_W-1:0]       div_q;
  logic                   tick;
  logic                   tick_clear;

  uart_rx_state_t         state, state_d;
  logic [OS_W-1:0]        os_cnt, os_d;
  logic [BIT_W-1:0]       bit_cnt, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   commit;

`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d;
  logic                   perr_hold;
`endif

  // Synchroniser resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset)
      sync_q <= '1;
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Divider is only captured while idle, so a mid-frame change waits for the next frame.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset)
      div_q <= '0;
    else if (state == RX_IDLE)
      div_q <= baud_div;
  end

  assign tick_clear = (state == RX_IDLE);

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk      (clk),
    .nReset   (nReset),
    .clear    (tick_clear),
    .baud_div (div_q),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      state   <= RX_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      os_cnt  <= os_d;
      bit_cnt <= bit_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    os_d    = os_cnt;
    bit_d   = bit_cnt;
    shift_d = shift_q;
    commit  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state)
      RX_IDLE: begin
        os_d  = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        perr_d = 1'b0;
`endif
        if (!rx_s)
          state_d = RX_START;
      end
      RX_START: begin
        if (tick) begin
          if (os_cnt == OS_W'(MID_SAMPLE - 1)) begin
            os_d    = '0;
            state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            os_d = os_cnt + OS_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            os_d    = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
          end else begin
            os_d = os_cnt + OS_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            os_d    = '0;
            perr_d  = rx_s ^ (^shift_q) ^ PARITY_ODD;
            state_d = RX_STOP;
          end else begin
            os_d = os_cnt + OS_W'(1);
          end
        end
      end
`endif
      RX_STOP: begin
        // Commit at mid stop bit and go straight to idle so a back-to-back
        // start edge is not missed.
        if (tick) begin
          if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            os_d    = '0;
            commit  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            os_d = os_cnt + OS_W'(1);
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Holding register: a commit wins over a simultaneous handshake.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rts       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_hold <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      rts     <= ~rx_valid;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data   <= shift_q;
          rx_valid  <= 1'b1;
          frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_hold <= perr_q;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid  <= 1'b0;
        frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_hold <= 1'b0;
`endif
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_hold;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed, table-driven bench for uart_rx_core.
// Honors UART_RX_PARITY_EN (frames carry an even parity bit when defined).
module tb_uart_rx_core;

  localparam int unsigned DIV  = 4;
  localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned TICKS = 8 + 16 * 10;
`else
  localparam int unsigned TICKS = 8 + 16 * 9;
`endif

  logic        clk      = 1'b0;
  logic        nReset   = 1'b1;
  logic        rx       = 1'b1;
  logic        rx_ready = 1'b0;
  logic [15:0] baud_div = 16'(DIV);
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;
  logic        rts;

  uart_rx_core #(
    .SYNC_STAGES (SYNC),
    .DIV_W       (16)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .rx         (rx),
    .baud_div   (baud_div),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .rts        (rts)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned ovr_cnt = 0;
  int unsigned rise_cnt = 0;
  int unsigned rise_cyc = 0;
  int unsigned start_cyc = 0;
  logic        prev_valid = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid && !prev_valid) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    prev_valid <= rx_valid;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Advance n clocks, ending 1 time unit after a rising edge.
  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(16 * DIV);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int unsigned n = 0;
    while (!rx_valid && n < 200) begin
      idle(1);
      n++;
    end
    chk({name, "_valid"}, 32'(rx_valid), 32'd1);
  endtask

  task automatic handshake(input string name);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    chk({name, "_valid_clr"}, 32'(rx_valid), 32'd0);
    chk({name, "_ferr_clr"}, 32'(frame_err), 32'd0);
    chk({name, "_perr_clr"}, 32'(parity_err), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int unsigned ovr0;
    int unsigned rise0;
    int unsigned lat;

    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[4] = '{8'h01, 1'b1, 8'h01, 1'b0};
    tbl[5] = '{8'h80, 1'b0, 8'h80, 1'b1};

    // Reset and idle
    idle(2);
    chk("rst_data",  32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_ferr",  32'(frame_err), 32'd0);
    chk("rst_perr",  32'(parity_err), 32'd0);
    chk("rst_ovr",   32'(overrun), 32'd0);
    chk("rst_rts",   32'(rts), 32'd0);
    nReset = 1'b0;
    chk("rts_before_edge", 32'(rts), 32'd0);
    idle(1);
    chk("rts_after_release", 32'(rts), 32'd1);
    idle(2000);
    chk("idle_no_valid", rise_cnt, 32'd0);

    // Glitch shorter than half a bit
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(32 * DIV);
    chk("glitch_ignored", rise_cnt, 32'd0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, ^tbl[i].data);
      wait_valid($sformatf("v%0d", i));
      chk($sformatf("v%0d_data", i), 32'(rx_data), 32'(tbl[i].exp_data));
      chk($sformatf("v%0d_ferr", i), 32'(frame_err), 32'(tbl[i].exp_ferr));
      chk($sformatf("v%0d_perr", i), 32'(parity_err), 32'd0);
      chk($sformatf("v%0d_rts", i), 32'(rts), 32'd0);
      if (i == 0) begin
        lat = rise_cyc - start_cyc;
        chk("latency_max", 32'(lat <= TICKS * DIV + SYNC + 2), 32'd1);
        chk("latency_min", 32'(lat >= TICKS * DIV), 32'd1);
      end
      idle(5);
      chk($sformatf("v%0d_held", i), 32'(rx_valid), 32'd1);
      handshake($sformatf("v%0d", i));
      idle(32 * DIV);
    end

    // Overrun: back-to-back with no consumer
    ovr0 = ovr_cnt;
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    idle(4);
    chk("ovr_data_kept", 32'(rx_data), 32'h11);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_pulse_once", ovr_cnt - ovr0, 32'd1);
    chk("ovr_rts", 32'(rts), 32'd0);
    handshake("ovr");
    idle(32 * DIV);

    // Ready on the exact commit cycle of the second frame
    ovr0 = ovr_cnt;
    send_frame(8'h11, 1'b1, ^8'h11);
    fork
      send_frame(8'h22, 1'b1, ^8'h22);
      begin
        idle(2 + TICKS * DIV);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(4);
    chk("rdy_commit_data", 32'(rx_data), 32'h22);
    chk("rdy_commit_valid", 32'(rx_valid), 32'd1);
    chk("rdy_commit_no_ovr", ovr_cnt - ovr0, 32'd0);
    handshake("rdy_commit");
    idle(32 * DIV);

    // Reset mid-frame
    ovr0  = ovr_cnt;
    rise0 = rise_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    nReset = 1'b1;
    idle(2);
    rx = 1'b1;
    nReset = 1'b0;
    idle(4);
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    chk("midrst_no_ovr", ovr_cnt - ovr0, 32'd0);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    wait_valid("midrst");
    chk("midrst_data", 32'(rx_data), 32'h5A);
    chk("midrst_one_byte", rise_cnt - rise0, 32'd1);
    handshake("midrst");
    idle(32 * DIV);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    wait_valid("par_ok");
    chk("par_ok_perr", 32'(parity_err), 32'd0);
    handshake("par_ok");
    idle(32 * DIV);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_valid("par_bad");
    chk("par_bad_perr", 32'(parity_err), 32'd1);
    chk("par_bad_data", 32'(rx_data), 32'h07);
    handshake("par_bad");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
